// File: rtl/bus_pkg.sv
// Shared bus types and widths for the register slave and any master that talks to it.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    // Wide enough to index the largest legal register file (64 entries).
    localparam int IDX_W  = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ADDR_PHASE = 2'd1,
        DATA_PHASE = 2'd2
    } state_t;

endpackage

// File: rtl/slave_reg_if.sv
// Request/response bus between a master and slave_reg.
// Optional err strobe is present only when SLAVE_REG_ERR_EN is defined.
interface slave_reg_if;
    import bus_pkg::*;

    // Handshake: the master raises valid with exactly one of read/write and holds the
    // request until it sees ready; ready is a one-cycle strobe and read_data/err are
    // meaningful only while ready is high.
    logic              valid;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic [DATA_W-1:0] read_data;

`ifdef SLAVE_REG_ERR_EN
    logic              err;

    modport master (output valid, read, write, addr, write_data,
                    input  ready, read_data, err);
    modport slave  (input  valid, read, write, addr, write_data,
                    output ready, read_data, err);
`else
    modport master (output valid, read, write, addr, write_data,
                    input  ready, read_data);
    modport slave  (input  valid, read, write, addr, write_data,
                    output ready, read_data);
`endif

endinterface

// File: rtl/slave_reg_bank.sv
// Register storage for slave_reg: one synchronous write port, one combinational read port.
module slave_reg_bank
    import bus_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int               AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int               DEPTH = 1 << AW;
    localparam logic [IDX_W:0]   LIMIT = (IDX_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     w_widx;
    logic [AW-1:0]     w_ridx;
    logic              w_wok;
    logic              w_rok;

    // Indices at or beyond NUM_REGS never touch storage, even if the caller lets one through.
    assign w_widx = i_widx[AW-1:0];
    assign w_ridx = i_ridx[AW-1:0];
    assign w_wok  = ({1'b0, i_widx} < LIMIT);
    assign w_rok  = ({1'b0, i_ridx} < LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_wok) begin
            r_mem[w_widx] <= i_wdata;
        end
    end

    assign o_rdata = w_rok ? r_mem[w_ridx] : '0;

endmodule

// File: rtl/slave_reg.sv
// Memory-mapped register slave: IDLE -> ADDR_PHASE (WAIT_CYCLES+1 cycles) -> DATA_PHASE.
// Define SLAVE_REG_ERR_EN to add the err strobe for out-of-range or misaligned accesses.
module slave_reg
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0010,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    slave_reg_if.slave  bus,
    output state_t      o_state
);

    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] SPAN      = (ADDR_W + 1)'(4 * NUM_REGS);

    state_t            r_state;
    logic [3:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic              r_ready;
    logic [DATA_W-1:0] r_read_data;

    logic [ADDR_W:0]   w_offset;
    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_we;
    logic [DATA_W-1:0] w_bank_rdata;

    // Decode works on the latched address, so bus activity after acceptance is invisible.
    assign w_offset = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_hit    = !w_offset[ADDR_W] && (w_offset < SPAN) && (r_addr[1:0] == 2'b00);
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_we     = (r_state == DATA_PHASE) && r_is_write && w_hit;

    slave_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_widx  (w_idx),
        .i_wdata (r_wdata),
        .i_ridx  (w_idx),
        .o_rdata (w_bank_rdata)
    );

`ifdef SLAVE_REG_ERR_EN
    logic r_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_ready     <= 1'b0;
            r_read_data <= '0;
`ifdef SLAVE_REG_ERR_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
`ifdef SLAVE_REG_ERR_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.valid && (bus.read ^ bus.write)) begin
                        r_addr     <= bus.addr;
                        r_wdata    <= bus.write_data;
                        r_is_write <= bus.write;
                        r_wait_cnt <= WAIT_INIT;
                        r_state    <= ADDR_PHASE;
                    end
                end
                ADDR_PHASE: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= DATA_PHASE;
                        r_ready <= 1'b1;
`ifdef SLAVE_REG_ERR_EN
                        r_err   <= !w_hit;
`endif
                        if (!r_is_write) begin
                            r_read_data <= w_hit ? w_bank_rdata : '0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                DATA_PHASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.read_data = r_read_data;
`ifdef SLAVE_REG_ERR_EN
    assign bus.err       = r_err;
`endif
    assign o_state       = r_state;

endmodule

// File: tb/tb_slave_reg.sv
// Directed bench for slave_reg: a WAIT_CYCLES=1 instance and a WAIT_CYCLES=0 instance.
module tb_slave_reg;
    import bus_pkg::*;

    logic   clk;
    logic   reset;
    state_t state0;
    state_t state1;
    int     total;
    int     bad;

    slave_reg_if bus0 ();
    slave_reg_if bus1 ();

    slave_reg #(.BASE_ADDR(16'h0010), .NUM_REGS(8), .WAIT_CYCLES(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus0),
        .o_state (state0)
    );

    slave_reg #(.BASE_ADDR(16'h0010), .NUM_REGS(8), .WAIT_CYCLES(0)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus1),
        .o_state (state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit inst, input logic v, input logic r, input logic w,
                         input logic [15:0] a, input logic [31:0] d);
        if (inst) begin
            bus1.valid = v; bus1.read = r; bus1.write = w; bus1.addr = a; bus1.write_data = d;
        end else begin
            bus0.valid = v; bus0.read = r; bus0.write = w; bus0.addr = a; bus0.write_data = d;
        end
    endtask

    function automatic logic get_ready(input bit inst);
        return inst ? bus1.ready : bus0.ready;
    endfunction

    function automatic logic [31:0] get_rdata(input bit inst);
        return inst ? bus1.read_data : bus0.read_data;
    endfunction

    function automatic logic get_err(input bit inst);
`ifdef SLAVE_REG_ERR_EN
        return inst ? bus1.err : bus0.err;
`else
        return inst ? 1'b0 : 1'b0;
`endif
    endfunction

    // One transfer; lat counts negedges after the accepting edge until ready (-1 on timeout).
    // Address and data are scrambled once the request is latched.
    task automatic txn(input bit inst, input bit wr, input logic [15:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        drive(inst, 1'b1, !wr, wr, a, d);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) drive(inst, 1'b1, !wr, wr, 16'h0014, 32'hFFFF_FFFF);
            if (get_ready(inst)) begin
                rd  = get_rdata(inst);
                er  = get_err(inst);
                got = 1'b1;
                break;
            end
        end
        drive(inst, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (state0 !== IDLE) begin bad++; $display("FAIL reset_state0: got %0d want %0d", state0, IDLE); end
        total++; if (bus0.ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b want 0", bus0.ready); end
        total++; if (bus0.read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata0: got %h want 0", bus0.read_data); end
        total++; if (state1 !== IDLE) begin bad++; $display("FAIL reset_state1: got %0d want %0d", state1, IDLE); end
        total++; if (bus1.ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b want 0", bus1.ready); end
        total++; if (bus1.read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata1: got %h want 0", bus1.read_data); end
`ifdef SLAVE_REG_ERR_EN
        total++; if (bus0.err !== 1'b0) begin bad++; $display("FAIL reset_err0: got %b want 0", bus0.err); end
`endif
    endtask

    task automatic test_write_latency();
        int lat; logic [31:0] rd; logic er;
        txn(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, lat, rd, er);
        total++; if (lat != 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata_hold: got %h want 0", rd); end
        @(negedge clk);
        total++; if (bus0.ready !== 1'b0) begin bad++; $display("FAIL ready_one_cycle: got %b want 0", bus0.ready); end
        total++; if (state0 !== IDLE) begin bad++; $display("FAIL back_to_idle: got %0d want %0d", state0, IDLE); end
        txn(1'b0, 1'b0, 16'h0010, 32'h0, lat, rd, er);
        total++; if (lat != 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_reg0: got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL rd_reg0_err: got %b want 0", er); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic er;
        txn(1'b0, 1'b1, 16'h001C, 32'h12345678, lat, rd, er);
        txn(1'b0, 1'b0, 16'h001C, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL rd_reg3: got %h want 12345678", rd); end
        txn(1'b0, 1'b1, 16'h002C, 32'hA5A5F00F, lat, rd, er);
        txn(1'b0, 1'b0, 16'h002C, 32'h0, lat, rd, er);
        total++; if (rd !== 32'hA5A5F00F) begin bad++; $display("FAIL rd_reg7: got %h want a5a5f00f", rd); end
        txn(1'b0, 1'b0, 16'h001C, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL rd_reg3_again: got %h want 12345678", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er;
        logic [15:0] bad_addr [3];
        bad_addr[0] = 16'h0030; bad_addr[1] = 16'h0012; bad_addr[2] = 16'h000C;
        for (int k = 0; k < 3; k++) begin
            txn(1'b0, 1'b0, bad_addr[k], 32'h0, lat, rd, er);
            total++; if (lat != 3) begin bad++; $display("FAIL oor_ready_%0h: latency got %0d want 3", bad_addr[k], lat); end
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rdata_%0h: got %h want 0", bad_addr[k], rd); end
`ifdef SLAVE_REG_ERR_EN
            total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_err_%0h: got %b want 1", bad_addr[k], er); end
`endif
        end
        txn(1'b0, 1'b1, 16'h0012, 32'hBAD0BAD0, lat, rd, er);
        txn(1'b0, 1'b1, 16'h0030, 32'hBAD1BAD1, lat, rd, er);
        txn(1'b0, 1'b0, 16'h0010, 32'h0, lat, rd, er);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL oor_write_dropped: got %h want deadbeef", rd); end
        txn(1'b0, 1'b1, 16'h0014, 32'h0BADCAFE, lat, rd, er);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold_on_write: got %h want deadbeef", rd); end
        txn(1'b0, 1'b0, 16'h0014, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h0BADCAFE) begin bad++; $display("FAIL rd_reg1: got %h want 0badcafe", rd); end
    endtask

    task automatic test_illegal_qualifiers();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'h11111111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bus0.ready !== 1'b0) begin bad++; $display("FAIL rw_both_ready: cycle %0d got %b want 0", i, bus0.ready); end
            total++; if (state0 !== IDLE) begin bad++; $display("FAIL rw_both_state: cycle %0d got %0d want %0d", i, state0, IDLE); end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (state0 !== IDLE) begin bad++; $display("FAIL rw_none_state: cycle %0d got %0d want %0d", i, state0, IDLE); end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0018, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        total++; if (state0 !== ADDR_PHASE) begin bad++; $display("FAIL abort_in_addr: got %0d want %0d", state0, ADDR_PHASE); end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (bus0.ready !== 1'b0) begin bad++; $display("FAIL abort_no_ready: cycle %0d got %b want 0", i, bus0.ready); end
        end
        total++; if (state0 !== IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", state0, IDLE); end
        reset = 1'b0;
        txn(1'b0, 1'b0, 16'h0018, 32'h0, lat, rd, er);
        total++; if (lat != 3) begin bad++; $display("FAIL abort_read_latency: got %0d want 3", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL abort_reg2: got %h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; int gap; logic [31:0] rd; logic er; bit got;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h11111111);
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus1.ready) begin lat = i; break; end
        end
        total++; if (lat != 2) begin bad++; $display("FAIL b2b_first_latency: got %0d want 2", lat); end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0014, 32'h22222222);
        gap = -1;
        got = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus1.ready) begin gap = i; got = 1'b1; break; end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        total++; if (!got || gap != 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", gap); end
        txn(1'b1, 1'b0, 16'h0010, 32'h0, lat, rd, er);
        total++; if (lat != 2) begin bad++; $display("FAIL b2b_read_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL b2b_reg0: got %h want 11111111", rd); end
        txn(1'b1, 1'b0, 16'h0014, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h22222222) begin bad++; $display("FAIL b2b_reg1: got %h want 22222222", rd); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
        repeat (3) @(posedge clk);
        test_reset();
        reset = 1'b0;
        test_write_latency();
        test_write_read();
        test_out_of_range();
        test_illegal_qualifiers();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_reg.md
SLAVE_REG -- requirements
Module: slave_reg

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0010: byte address of register 0.
REQ-002 Parameter NUM_REGS, default 8: number of 32-bit registers; legal range 1..64.
REQ-003 Parameter WAIT_CYCLES, default 1: extra cycles spent in ADDR_PHASE; legal range 0..15.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 valid  input  1  master request strobe, held until ready.
REQ-008 read  input  1  read request qualifier.
REQ-009 write  input  1  write request qualifier.
REQ-010 addr  input  16  byte address.
REQ-011 write_data  input  32  write payload.
REQ-012 ready  output  1  one-cycle completion strobe.
REQ-013 read_data  output  32  read payload, valid while ready is high.
REQ-014 err  output  1  address-error strobe; present only when SLAVE_REG_ERR_EN is defined.

Function
REQ-015 The FSM SHALL use the states IDLE, ADDR_PHASE and DATA_PHASE; all outputs SHALL be registered.
REQ-016 In IDLE, valid=1 with exactly one of read or write SHALL latch addr, write_data and the direction, then move to ADDR_PHASE.
REQ-017 valid=1 with read=write=1, or with read=write=0, SHALL be ignored; the FSM stays in IDLE.
REQ-018 ADDR_PHASE SHALL decode the address and last WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter; it then moves to DATA_PHASE.
REQ-019 DATA_PHASE SHALL last exactly 1 cycle with ready=1, then return to IDLE.
REQ-020 Latency SHALL be WAIT_CYCLES+2 cycles from the edge that samples valid to the first cycle in which ready is high.
REQ-021 An address is in range when it is >= BASE_ADDR, < BASE_ADDR+4*NUM_REGS, and addr[1:0]==0; the register index is (addr-BASE_ADDR)>>2.
REQ-022 An in-range write SHALL update the register at the DATA_PHASE edge; the new value is readable by the next transaction.
REQ-023 An in-range read SHALL drive the register value on read_data in the DATA_PHASE cycle; read_data holds until the next read completes.
REQ-024 An out-of-range write SHALL be dropped; an out-of-range read SHALL return 32'h0.
REQ-025 Changes on valid, addr or write_data after the request is latched SHALL have no effect until the FSM is back in IDLE.
REQ-026 A new request SHALL be accepted no earlier than the cycle after DATA_PHASE, giving a minimum spacing of WAIT_CYCLES+3 cycles between back-to-back transfers.

Reset
REQ-027 With reset high at a clock edge: state=IDLE, ready=0, read_data=32'h0, err=0, wait counter=0, all registers=32'h0.
REQ-028 Reset mid-transaction SHALL abort it with no register write and no ready pulse; reset has priority over every other event.

Configuration
REQ-029 With SLAVE_REG_ERR_EN defined, err SHALL pulse high together with ready for out-of-range or misaligned accesses, and SHALL be 0 otherwise.
REQ-030 With SLAVE_REG_ERR_EN undefined, the err port and its logic SHALL be absent; REQ-024 still applies.

Structure
REQ-031 Shared package bus_pkg SHALL hold state_t (IDLE, ADDR_PHASE, DATA_PHASE), ADDR_W=16 and DATA_W=32; master and slave SHALL both import it.
REQ-032 Register storage SHALL be a sub-module slave_reg_bank with one write port and one read port; the decode and FSM SHALL stay in slave_reg.

Verification
REQ-033 Write 32'hDEADBEEF to 16'h0010 with WAIT_CYCLES=1 -> ready high exactly 3 cycles after valid is sampled, and register 0 = 32'hDEADBEEF.
REQ-034 Write then read 16'h001C (register 3) with 32'h12345678 -> read_data=32'h12345678 in the read's ready cycle.
REQ-035 Read 16'h0030 (out of range) and 16'h0012 (misaligned) -> read_data=32'h0, ready pulses; err=1 when SLAVE_REG_ERR_EN is defined.
REQ-036 valid with read=write=1 for 5 cycles -> ready stays 0 and the state stays IDLE.
REQ-037 Reset asserted during ADDR_PHASE of a write of 32'hCAFEF00D -> no ready pulse, and a subsequent read of that address returns 32'h0.
REQ-038 WAIT_CYCLES=0 back-to-back writes to registers 0 and 1 -> ready pulses 3 cycles apart and both values are stored.
